// File: rtl/br_gen_frac.sv
// br_gen_frac: fractional baud-rate generator with a loadable divisor.
// Define BR_GEN_FRAC_EN to build in the fractional accumulator.
module br_gen_frac #(
  parameter int CLK_RATE   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int DIV_RST    = int'((longint'(CLK_RATE) << FRAC_W)
                             / (longint'(BAUD_RATE) * OVERSAMPLE))
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    SYNC,
  input  logic [INT_W+FRAC_W-1:0] DIV_IN,
  input  logic                    DIV_LOAD,
  output logic                    DIV_BUSY,
  output logic                    TICK,
  output logic                    BIT_TICK
);

  localparam int DW   = INT_W + FRAC_W;
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [INT_W-1:0] RST_INT = INT_W'(DIV_RST >> FRAC_W);

  function automatic logic [INT_W-1:0] clamp(input logic [INT_W-1:0] v);
    return (v < INT_W'(2)) ? INT_W'(2) : v;
  endfunction

  logic [INT_W-1:0] cnt_q, cnt_d;
  logic [INT_W-1:0] div_q, div_d;
  logic [DW-1:0]    shd_q, shd_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             bit_q, bit_d;

  logic             ext;
  logic [INT_W:0]   lim;
  logic             at_end;
  logic             load_ok;
  logic [DW-1:0]    pend;
  logic             apply;
  logic             clr;
  logic             adv;

  assign load_ok = DIV_LOAD & ~busy_q;
  // A load on a SYNC edge bypasses the shadow register.
  assign pend    = load_ok ? DIV_IN : shd_q;
  assign lim     = {1'b0, div_q} + (INT_W+1)'(ext) - (INT_W+1)'(1);
  // >= rather than == so a shrinking divisor can never let cnt run away.
  assign at_end  = ({1'b0, cnt_q} >= lim);

  // Next-state for period counter, tick counters and the load handshake.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    os_d   = os_q;
    busy_d = busy_q;
    tick_d = 1'b0;
    bit_d  = 1'b0;
    apply  = 1'b0;
    adv    = 1'b0;
    if (load_ok) begin
      shd_d  = DIV_IN;
      busy_d = 1'b1;
    end
    if (SYNC) begin
      cnt_d = '0;
      os_d  = '0;
      apply = busy_q | load_ok;
    end else if (!EN) begin
      apply = busy_q;
    end else if (at_end) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      adv    = 1'b1;
      bit_d  = (os_q == OS_LAST);
      os_d   = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
      apply  = busy_q;
    end else begin
      cnt_d = cnt_q + INT_W'(1);
    end
    if (apply) begin
      div_d  = clamp(pend[DW-1:FRAC_W]);
      busy_d = 1'b0;
    end
  end

  assign clr = SYNC | apply;

  // Main state registers; outputs are taken straight from flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      div_q  <= RST_INT;
      shd_q  <= '0;
      os_q   <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      os_q   <= os_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
      bit_q  <= bit_d;
    end
  end

`ifdef BR_GEN_FRAC_EN
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DIV_RST);

  logic [FRAC_W-1:0] dfr_q, dfr_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W:0]   acc_sum;

  assign ext     = ext_q;
  assign acc_sum = {1'b0, acc_q} + {1'b0, dfr_q};

  // Fraction accumulates per tick; the carry stretches the next period.
  always_comb begin
    dfr_d = dfr_q;
    acc_d = acc_q;
    ext_d = ext_q;
    if (clr) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (adv) begin
      {ext_d, acc_d} = acc_sum;
    end
    if (apply) begin
      dfr_d = pend[FRAC_W-1:0];
    end
  end

  // Fractional divisor and accumulator registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dfr_q <= RST_FRAC;
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      dfr_q <= dfr_d;
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
  end
`else
  logic frac_unused;
  logic clr_unused;
  logic adv_unused;

  assign ext         = 1'b0;
  assign frac_unused = ^pend[FRAC_W-1:0];
  assign clr_unused  = clr;
  assign adv_unused  = adv;
`endif

  assign DIV_BUSY = busy_q;
  assign TICK     = tick_q;
  assign BIT_TICK = bit_q;

endmodule

// File: tb/tb_br_gen_frac.sv
// tb_br_gen_frac: directed bench for the fractional baud generator.
// Expected periods follow BR_GEN_FRAC_EN when it is defined.
module tb_br_gen_frac;

  localparam int DW = 20;
`ifdef BR_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          sync;
  logic [DW-1:0] div_in;
  logic          div_load;
  logic          busy;
  logic          tick;
  logic          bit_tick;

  int errors;
  int checks;
  int stray;
  int busy_hi;

  br_gen_frac dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .EN       (en),
    .SYNC     (sync),
    .DIV_IN   (div_in),
    .DIV_LOAD (div_load),
    .DIV_BUSY (busy),
    .TICK     (tick),
    .BIT_TICK (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Divisor with fraction 8: odd periods from the 3rd on are one longer.
  function automatic int exp_per(input int k, input int base);
    return base + ((FRAC_ON && k >= 3 && (k % 2) == 1) ? 1 : 0);
  endfunction

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!tick && bit_tick) stray++;
      if (!tick && busy) busy_hi++;
    end while (!tick && n < lim);
    chk("tick_seen", int'(tick), 1);
  endtask

  task automatic load(input logic [DW-1:0] v);
    div_in   = v;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  initial begin
    int n;
    int tot;
    int pulses;
    errors   = 0;
    checks   = 0;
    stray    = 0;
    busy_hi  = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    sync     = 1'b0;
    div_load = 1'b0;
    div_in   = '0;

    repeat (3) step();
    chk("rst_tick", int'(tick), 0);
    chk("rst_bit", int'(bit_tick), 0);
    chk("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    en    = 1'b1;
    tot   = 0;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(400, n);
      chk("def_per", n, exp_per(k, 325));
      chk("def_bit", int'(bit_tick), int'(k % 16 == 0));
      tot += n;
    end
    chk("def_sum", tot, FRAC_ON ? 10415 : 10400);
    chk("def_stray", stray, 0);

    repeat (50) step();
    en     = 1'b0;
    pulses = 0;
    repeat (100) begin
      step();
      pulses += int'(tick) + int'(bit_tick);
    end
    chk("en_off_pulses", pulses, 0);
    en = 1'b1;
    wait_tick(400, n);
    chk("en_resume", n + 150, exp_per(33, 325) + 100);

    repeat (10) step();
    load(20'h00020);
    chk("ld_busy", int'(busy), 1);
    load(20'h00050);
    chk("ld_ign_busy", int'(busy), 1);
    busy_hi = 0;
    wait_tick(400, n);
    chk("ld_wait", n, 313);
    chk("ld_busy_hi", busy_hi, 312);
    chk("ld_busy_drop", int'(busy), 0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(10, n);
      chk("div2_per", n, 2);
    end

    load(20'h00058);
    chk("ld58_busy", int'(busy), 1);
    wait_tick(20, n);
    chk("ld58_drop", int'(busy), 0);
    for (int k = 1; k <= 5; k++) begin
      wait_tick(20, n);
      chk("div58_per", n, exp_per(k, 5));
    end

    load(20'h00000);
    wait_tick(20, n);
    chk("clamp_drop", int'(busy), 0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(10, n);
      chk("clamp_per", n, 2);
    end

    load(20'h00058);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_bit", int'(bit_tick), 0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_tick(400, n);
    chk("rst_div", n, 325);

    pulses = 0;
    repeat (324) begin
      step();
      pulses += int'(tick);
    end
    chk("pre_sync_quiet", pulses, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick", int'(tick), 0);
    chk("sync_bit0", int'(bit_tick), 0);
    stray = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(400, n);
      chk("sync_per", n, exp_per(k, 325));
      chk("sync_bit", int'(bit_tick), int'(k == 16));
    end
    chk("sync_stray", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/br_gen_frac.md
# br_gen_frac

Fractional, runtime-programmable baud-rate generator. It produces a one-cycle oversample tick (`TICK`) for the UART receiver and transmitter, plus a bit-rate tick (`BIT_TICK`) every `OVERSAMPLE` ticks. It sits between the board clock and the UART RX/TX blocks. It replaces the fixed integer divider with:
- a fixed-point divisor, loaded at run time through a handshake;
- an enable input;
- a phase-resync input.

## Interface
- `CLK_RATE`, 50000000: board clock frequency in Hz.
- `BAUD_RATE`, 9600: baud rate used to build the reset-default divisor.
- `OVERSAMPLE`, 16: number of `TICK` pulses per `BIT_TICK` (≥2).
- `INT_W`, 16: width of the integer part of the divisor.
- `FRAC_W`, 4: width of the fractional part of the divisor.
- `DIV_RST`, (CLK_RATE·2^FRAC_W)/(BAUD_RATE·OVERSAMPLE), truncated: reset divisor. Default value is 5208, i.e. integer part 325, fraction 8.

Ports:
- `CLK`  in  1: board clock; all logic on its rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `EN`  in  1: count enable; when low, all counters freeze.
- `SYNC`  in  1: phase restart; clears all counters.
- `DIV_IN`  in  INT_W+FRAC_W: new divisor. Bits [INT_W+FRAC_W-1:FRAC_W] are the integer part, bits [FRAC_W-1:0] are the fraction.
- `DIV_LOAD`  in  1: load request, sampled as a single-cycle strobe.
- `DIV_BUSY`  out 1: a loaded divisor is pending and not yet applied.
- `TICK`  out 1: oversample tick, one cycle wide, registered.
- `BIT_TICK`  out 1: bit tick, one cycle wide, registered, coincident with every `OVERSAMPLE`-th `TICK`.

## Operation
- State:
  - `cnt`: INT_W bits, period counter.
  - `frac_acc`: FRAC_W bits, fractional accumulator.
  - `ext`: 1 bit, extends the current period by one cycle.
  - `os_cnt`: clog2(OVERSAMPLE) bits, counts `TICK`s.
  - Active divisor and shadow divisor.
- Period of the current tick: `div_int + ext` cycles.
- On each enabled edge:
  - If `cnt == div_int + ext - 1`:
    - set `TICK` to 1 and set `cnt` to 0;
    - compute `{carry, frac_acc} ← frac_acc + div_frac`;
    - set `ext ← carry`;
    - advance `os_cnt`, wrapping from OVERSAMPLE-1 to 0;
    - set `BIT_TICK` to 1 when `os_cnt` was OVERSAMPLE-1.
  - Otherwise increment `cnt`.
- Average tick period is DIV/2^FRAC_W cycles. Long-run error is zero; per-tick jitter is at most 1 cycle.
- Divisor clamp: an integer part below 2 is clamped to 2 when applied. The fraction is unaffected.
- Load handshake:
  - `DIV_LOAD=1` with `DIV_BUSY=0` captures `DIV_IN` into the shadow register and sets `DIV_BUSY=1` on the next edge.
  - `DIV_LOAD` while `DIV_BUSY=1` is ignored; the first pending value wins.
  - The pending value is applied at the next tick boundary, on the same edge that asserts `TICK`. On that edge `frac_acc` and `ext` are cleared and `DIV_BUSY` drops.
  - If `EN=0`, the pending value is applied on the next edge.
- `SYNC=1`:
  - clears `cnt`, `frac_acc`, `ext` and `os_cnt`;
  - applies any pending divisor immediately;
  - forces `TICK=BIT_TICK=0` that cycle.
  - `SYNC` overrides a coincident tick boundary and works regardless of `EN`.
  - A `DIV_LOAD` on the same edge as `SYNC` is captured and applied on that same edge.
- `EN=0`: all counters hold, `TICK=BIT_TICK=0`.

## Timing
- Reset values (asynchronous): `TICK=0`, `BIT_TICK=0`, `DIV_BUSY=0`, `cnt=0`, `frac_acc=0`, `ext=0`, `os_cnt=0`, active divisor = `DIV_RST`.
- First `TICK` is high during the cycle following the `div_int`-th enabled edge after reset release or `SYNC`.
- Latency from `DIV_LOAD` to `DIV_BUSY`: 1 edge.
- `DIV_BUSY` stays high for at most `div_int + 1` cycles while `EN=1`.
- `RST_N` asserted mid-period aborts the period. No partial pulse is emitted.
- `cnt` never exceeds `div_int` and never wraps.

## Configuration
- `BR_GEN_FRAC_EN` defined:
  - the fractional accumulator is present;
  - periods are `div_int` or `div_int + 1` as described above.
- `BR_GEN_FRAC_EN` not defined:
  - `frac_acc` and `ext` are removed and `ext` is treated as 0;
  - `DIV_IN[FRAC_W-1:0]` and the fraction of `DIV_RST` are ignored;
  - every period is exactly `div_int` cycles;
  - port widths are unchanged.

## Test plan
- Reset, `EN=1`, default divisor, macro defined -> `TICK` periods are 325, 325, 326, 325, 326, ... cycles. The first `BIT_TICK` coincides with the 16th `TICK`. Over 32 ticks, the total is 10416 cycles ±1.
- Same stimulus, macro undefined -> every `TICK` period is 325 cycles. `BIT_TICK` period is 5200 cycles.
- `DIV_LOAD` with `DIV_IN=0x0020` (integer 2, fraction 0) mid-period -> `DIV_BUSY=1` for one cycle after the load. Then `DIV_BUSY` stays high until the next `TICK`. After that, `TICK` repeats every 2 cycles. A second `DIV_LOAD` while busy is ignored.
- `DIV_IN=0x0000` loaded -> integer part clamped to 2, so `TICK` repeats every 2 cycles.
- `SYNC` pulsed on the edge where a tick is due -> no `TICK` on that edge. The next `TICK` follows `div_int` edges later. `os_cnt` restarts, so `BIT_TICK` comes 16 ticks later.
- `EN` low for 100 cycles mid-period -> no pulses during that time. The period resumes and completes, lengthened by exactly 100 cycles. `RST_N` pulsed low mid-period -> all outputs go to 0 immediately and the divisor returns to 5208.
